// File: rtl/axis_line_arbiter.sv
// axis_line_arbiter
//   Packet-level round-robin arbiter. Several upstream AXI4-Stream line sources
//   share one downstream port. Once a source wins, it keeps the grant until its
//   TLAST beat is accepted downstream.
//
//   Ports
//     AXIS_ACLK / AXIS_ARESET     clock, asynchronous active-high reset
//     S_AXIS_*  (NUM_SRC lanes)   upstream sources, packed per lane
//     M_AXIS_*                    downstream port; TID carries the granted index
//     ARB_BUSY                    high while a packet is locked
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no packet locked; round-robin pick among valid sources
//   XFER   | grant locked; granted lane muxed through until its TLAST beat
module axis_line_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 32,
  parameter int ID_WIDTH    = 2
) (
  input  logic                               AXIS_ACLK,
  input  logic                               AXIS_ARESET,
  input  logic [NUM_SRC-1:0]                 S_AXIS_TVALID,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [NUM_SRC*TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic [NUM_SRC-1:0]                 S_AXIS_TLAST,
  input  logic [NUM_SRC-1:0]                 S_AXIS_TUSER,
  output logic [NUM_SRC-1:0]                 S_AXIS_TREADY,
  output logic                               M_AXIS_TVALID,
  output logic [TDATA_WIDTH-1:0]             M_AXIS_TDATA,
  output logic [TDATA_WIDTH/8-1:0]           M_AXIS_TSTRB,
  output logic                               M_AXIS_TLAST,
  output logic                               M_AXIS_TUSER,
  output logic [ID_WIDTH-1:0]                M_AXIS_TID,
  input  logic                               M_AXIS_TREADY,
  output logic                               ARB_BUSY
);

  localparam int STRB_WIDTH = TDATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;

  logic [ID_WIDTH-1:0]   pick;
  logic                  pick_vld;
  logic                  sel_valid;
  logic [TDATA_WIDTH-1:0] sel_data;
  logic [STRB_WIDTH-1:0] sel_strb;
  logic                  sel_last;
  logic                  sel_user;

  // Round-robin scan starting one past the last winner. Walking k downwards
  // lets the smallest offset overwrite the others, so the first hit wins.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NUM_SRC;
      if (S_AXIS_TVALID[idx]) begin
        pick     = ID_WIDTH'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Lane mux for the current grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = S_AXIS_TVALID[i];
        sel_data  = S_AXIS_TDATA[i*TDATA_WIDTH +: TDATA_WIDTH];
        sel_strb  = S_AXIS_TSTRB[i*STRB_WIDTH +: STRB_WIDTH];
        sel_last  = S_AXIS_TLAST[i];
        sel_user  = S_AXIS_TUSER[i];
      end
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(NUM_SRC - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    S_AXIS_TREADY = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TSTRB  = '0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TUSER  = 1'b0;
    M_AXIS_TID    = grant_q;
    ARB_BUSY      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        ARB_BUSY      = 1'b1;
        M_AXIS_TVALID = sel_valid;
        M_AXIS_TDATA  = sel_data;
        M_AXIS_TSTRB  = sel_strb;
        M_AXIS_TLAST  = sel_last;
        M_AXIS_TUSER  = sel_user;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_q == ID_WIDTH'(i)) S_AXIS_TREADY[i] = M_AXIS_TREADY;
        end
        // Grant is released only on an accepted TLAST beat; a stalled source
        // keeps the port.
        if (sel_valid && M_AXIS_TREADY && sel_last) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
